// File: rtl/riscv_pkg.sv
// Shared RISC-V M-extension definitions: op codes, muldiv FSM states and default XLEN.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_MUL    = 7'b0011000;
    localparam logic [6:0] OP_MULH   = 7'b0011001;
    localparam logic [6:0] OP_MULHSU = 7'b0011010;
    localparam logic [6:0] OP_MULHU  = 7'b0011011;
    localparam logic [6:0] OP_DIV    = 7'b0010000;
    localparam logic [6:0] OP_DIVU   = 7'b0010001;
    localparam logic [6:0] OP_REM    = 7'b0010010;
    localparam logic [6:0] OP_REMU   = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    // Mul ops are 00110xx and div ops are 00100xx.
    function automatic logic is_md_op(input logic [6:0] op);
        return (op[6:4] == 3'b001) && (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module md_cond_neg #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] value,
    input  logic            neg,
    output logic [XLEN-1:0] y
);

    assign y = neg ? ('0 - value) : value;

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative radix-2 RISC-V multiply/divide unit (IDLE -> CALC -> FIX -> DONE).
// Define RISCV_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier on mul-class ops.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            start,
    input  logic [6:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned    CW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e state, state_next;

    logic            mul_q;
    logic [1:0]      sel_q;
    logic            sign_flip;
    logic            a_neg;
    logic [XLEN-1:0] hi, lo, mcand;
    logic [CW-1:0]   cnt;

    logic            is_mul, a_signed, b_signed, a_sneg, b_sneg;
    logic            div_zero, div_ovf, accept, shortcut;
    logic [XLEN-1:0] a_abs, b_abs;

    assign is_mul   = op[3];
    assign a_signed = is_mul ? (op[1:0] != 2'b11) : !op[0];
    assign b_signed = is_mul ? !op[1] : !op[0];
    assign a_sneg   = a_signed & a[XLEN-1];
    assign b_sneg   = b_signed & b[XLEN-1];
    assign div_zero = !is_mul && (b == '0);
    assign div_ovf  = !is_mul && !op[0] && (a == SMIN) && (b == '1);
    assign accept   = (state == IDLE) && start && !flush && is_md_op(op);

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
    assign a_ext     = a_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    assign b_ext     = b_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    assign fast_prod = a_ext * b_ext;
    assign shortcut  = div_zero | div_ovf | is_mul;
`else
    assign shortcut  = div_zero | div_ovf;
`endif

    md_cond_neg #(.XLEN(XLEN)) u_neg_a (.value(a), .neg(a_sneg), .y(a_abs));
    md_cond_neg #(.XLEN(XLEN)) u_neg_b (.value(b), .neg(b_sneg), .y(b_abs));

    // Sign correction applied in FIX on the full product and on quotient/remainder.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   dr_raw, dr_fix, fix_val;
    logic              dr_neg;

    assign dr_raw = sel_q[1] ? hi : lo;
    assign dr_neg = sel_q[1] ? a_neg : sign_flip;

    md_cond_neg #(.XLEN(2*XLEN)) u_neg_prod (.value({hi, lo}), .neg(sign_flip), .y(prod_fix));
    md_cond_neg #(.XLEN(XLEN))   u_neg_dr   (.value(dr_raw), .neg(dr_neg), .y(dr_fix));

    always_comb begin
        fix_val = dr_fix;
        if (mul_q) begin
            fix_val = (sel_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0] mul_sum, div_shift, div_diff;
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand};

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = shortcut ? DONE : CALC;
            end
            CALC: begin
                if (flush)           state_next = IDLE;
                else if (cnt == '0)  state_next = FIX;
            end
            FIX:     state_next = flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready        = (state == IDLE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_q     <= 1'b0;
            sel_q     <= '0;
            sign_flip <= 1'b0;
            a_neg     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            cnt       <= '0;
            result    <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mul_q     <= is_mul;
                        sel_q     <= op[1:0];
                        sign_flip <= a_sneg ^ b_sneg;
                        a_neg     <= a_sneg;
                        cnt       <= CW'(XLEN - 1);
                        hi        <= '0;
                        if (is_mul) begin
                            mcand <= a_abs;
                            lo    <= b_abs;
                        end else begin
                            mcand <= b_abs;
                            lo    <= a_abs;
                        end
                        if (div_zero) begin
                            result <= op[1] ? a : '1;
                        end else if (div_ovf) begin
                            result <= op[1] ? '0 : a;
                        end
`ifdef RISCV_MULDIV_FAST_MUL_EN
                        else if (is_mul) begin
                            {hi, lo} <= fast_prod;
                            result   <= (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                           : fast_prod[2*XLEN-1:XLEN];
                        end
`endif
                    end
                end
                CALC: begin
                    if (!flush) begin
                        if (mul_q) begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end else if (!div_diff[XLEN]) begin
                            hi <= div_diff[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                        if (cnt != '0) cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (!flush) result <= fix_val;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv (XLEN=32): directed corner cases plus random ops
// against a plain-arithmetic reference model; honours RISCV_MULDIV_FAST_MUL_EN latency.
module tb_riscv_muldiv;

    localparam logic [6:0] T_MUL    = 7'b0011000;
    localparam logic [6:0] T_MULH   = 7'b0011001;
    localparam logic [6:0] T_MULHSU = 7'b0011010;
    localparam logic [6:0] T_MULHU  = 7'b0011011;
    localparam logic [6:0] T_DIV    = 7'b0010000;
    localparam logic [6:0] T_DIVU   = 7'b0010001;
    localparam logic [6:0] T_REM    = 7'b0010010;
    localparam logic [6:0] T_REMU   = 7'b0010011;

    logic        clock = 1'b0;
    logic        rst_n, start, flush;
    logic [6:0]  op;
    logic [31:0] a, b;
    logic        ready, result_valid;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    riscv_muldiv #(.XLEN(32)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .ready(ready), .result_valid(result_valid), .result(result)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: full-width arithmetic on extended operands, C-style signed division.
    function automatic void model(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat);
        logic [63:0] xe, ye, p;
        int sx, sy;
        sx  = $signed(x);
        sy  = $signed(y);
        lat = 34;
        r   = '0;
        if (o[3]) begin
            xe = (o != T_MULHU) ? {{32{x[31]}}, x} : {32'h0, x};
            ye = (o == T_MUL || o == T_MULH) ? {{32{y[31]}}, y} : {32'h0, y};
            p  = xe * ye;
            r  = (o == T_MUL) ? p[31:0] : p[63:32];
`ifdef RISCV_MULDIV_FAST_MUL_EN
            lat = 1;
`endif
        end else if (y == 32'h0) begin
            r   = (o == T_DIV || o == T_DIVU) ? 32'hFFFF_FFFF : x;
            lat = 1;
        end else if ((o == T_DIV || o == T_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r   = (o == T_DIV) ? x : 32'h0;
            lat = 1;
        end else begin
            case (o)
                T_DIV:   r = sx / sy;
                T_DIVU:  r = x / y;
                T_REM:   r = sx % sy;
                default: r = x % y;
            endcase
        end
    endfunction

    task automatic issue(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_it);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clock);
        while (!ready && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1 start = 1'b0;
        if (expect_it) begin
            model(o, x, y, e.res, e.lat);
            e.acc    = cyc;
            last_exp = e.res;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    // Monitor: pops one expectation per result_valid pulse; ready must stay low while busy.
    always @(negedge clock) begin
        exp_t e;
        if (rst_n) begin
            if (result_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("latency", cyc - e.acc + 1, e.lat);
                end
            end else if (sb.size() > 0) begin
                check("ready_busy", ready, 1'b0);
            end
        end
    end

    logic [6:0]  d_op[16];
    logic [31:0] d_a[16];
    logic [31:0] d_b[16];
    logic [6:0]  all_ops[8];

    initial begin
        start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rst_n = 1'b0;
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_valid", result_valid, 1'b0);
        check("reset_result", result, 32'h0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;

        d_op = '{T_MUL, T_MUL, T_MULH, T_MULHU, T_MULHSU, T_DIV, T_REM, T_DIVU,
                 T_REMU, T_DIVU, T_REMU, T_DIV, T_REM, T_DIV, T_REM, T_MULHSU};
        d_a  = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000};
        d_b  = '{32'hFFFF_FFFD, 32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);

        // Start while busy is ignored; the in-flight op must still complete correctly.
        issue(T_DIVU, 32'd1000, 32'd9, 1'b1);
        @(negedge clock);
        start = 1'b1; op = T_MUL; a = 32'd3; b = 32'd3;
        @(posedge clock);
        #1 start = 1'b0;
        drain();

        // Unknown op code is ignored.
        @(negedge clock);
        start = 1'b1; op = 7'b0110011; a = 32'd1; b = 32'd1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        check("invalid_op_ready", ready, 1'b1);

        all_ops = '{T_MUL, T_MULH, T_MULHSU, T_MULHU, T_DIV, T_DIVU, T_REM, T_REMU};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                default: ;
            endcase
            issue(all_ops[$urandom_range(0, 7)], ra, rb, 1'b1);
        end
        drain();

        // Flush mid-CALC: no pulse, ready next cycle, result untouched.
        issue(T_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_ready", ready, 1'b1);
        check("flush_result", result, last_exp);
        repeat (40) @(negedge clock);

        // Flush together with start in IDLE: start dropped.
        start = 1'b1; flush = 1'b1; op = T_DIVU; a = 32'd9; b = 32'd0;
        @(posedge clock);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clock);
        check("flush_start_ready", ready, 1'b1);
        repeat (5) @(negedge clock);

        // Asynchronous reset mid-operation.
        issue(T_DIVU, 32'd12345, 32'd7, 1'b0);
        repeat (10) @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_result", result, 32'h0);
        check("midreset_ready", ready, 1'b1);
        check("midreset_valid", result_valid, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (40) @(negedge clock);

        issue(T_REMU, 32'd100, 32'd7, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
